// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared definitions for the digit-serial adder/subtractor.
//   op encodings : OP_ADD, OP_SUB, OP_ADDS, OP_SUBS
//   state_t      : controller states IDLE, RUN, DONE
package serial_addsub_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDS = 2'b10;
  localparam logic [1:0] OP_SUBS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder.
//   a, b : DIGIT-bit addends
//   cin  : carry in
//   s    : DIGIT-bit sum
//   cout : carry out of the top bit
//   cmsb : carry into the top bit (used for signed overflow)
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle two's-complement adder/subtractor processing
// DIGIT bits per clock, LSB digit first, with optional saturation.
//   clk, rst         : clock, synchronous active-high reset
//   start, op        : request and operation (add/sub/sat add/sat sub)
//   inputA, inputB   : WIDTH-bit operands, latched with start
//   busy             : high while digits are being processed
//   done             : one-cycle pulse when sum/carry/overflow update
//   sum              : result sign-extended to 2*WIDTH
//   carry, overflow  : raw carry out of MSB, signed overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   inputA,
  input  logic [WIDTH-1:0]   inputB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] sum,
  output logic               carry,
  output logic               overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t                 state;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       res;
  logic                   c_r;
  logic                   sat_r;
  logic                   a_sign;
  logic [CW-1:0]          cnt;

  logic [DIGIT-1:0]       ds;
  logic                   dcout;
  logic                   dcmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_full;
  logic [WIDTH-1:0]       res_final;
  logic                   ov_final;

  // Operands shift right so the current digit is always at the bottom.
  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (c_r),
    .s    (ds),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // New digit enters at the top of the result register; after N shifts the
  // first digit has reached bit 0. Shifting the concatenation (rather than
  // slicing) keeps this valid when DIGIT == WIDTH.
  always_comb begin
    res_cat   = {ds, res};
    res_full  = WIDTH'(res_cat >> DIGIT);
    // Only meaningful on the last digit, where dcmsb is carry into the MSB.
    ov_final  = dcout ^ dcmsb;
    res_final = res_full;
    if (sat_r && ov_final) begin
      res_final = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      c_r      <= 1'b0;
      sat_r    <= 1'b0;
      a_sign   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= inputA;
            b_sh   <= inputB ^ {WIDTH{op[0]}};
            c_r    <= op[0];
            sat_r  <= op[1];
            a_sign <= inputA[WIDTH-1];
            cnt    <= '0;
            res    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          res  <= res_full;
          c_r  <= dcout;
          if (cnt == CW'(N - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            carry    <= dcout;
            overflow <= ov_final;
            sum      <= {{WIDTH{res_final[WIDTH-1]}}, res_final};
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, carry, overflow;
  logic [31:0] sum;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy1, done1, carry1, ov1;
  logic [15:0] sum1;
  logic        busy8, done8, carry8, ov8;
  logic [15:0] sum8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .inputA(a), .inputB(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .inputA(a8), .inputB(b8),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ov1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .inputA(a8), .inputB(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ov8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation; lat counts sampled cycles from the accepting edge
  // until done is seen, bcnt counts cycles with busy high before that.
  task automatic launch(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb,
                        output int lat, output int bcnt);
    op = o; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 00000000", sum); end
    checks++; if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {carry, overflow}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int lat, bc;
    launch(OP_ADD, 16'd6, 16'd1, lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency got %0d want 5", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d want 4", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_with_done got %b want 0", busy); end
    checks++; if (sum !== 32'h00000007) begin errors++; $display("FAIL add_sum got %h want 00000007", sum); end
    checks++; if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL add_flags got %b want 00", {carry, overflow}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", done); end
    checks++; if (sum !== 32'h00000007) begin errors++; $display("FAIL add_sum_hold got %h want 00000007", sum); end
  endtask

  task automatic test_sub();
    int lat, bc;
    launch(OP_SUB, 16'd6, 16'd1, lat, bc);
    checks++; if (sum !== 32'h00000005) begin errors++; $display("FAIL sub_6_1_sum got %h want 00000005", sum); end
    checks++; if ({carry, overflow} !== 2'b10) begin errors++; $display("FAIL sub_6_1_flags got %b want 10", {carry, overflow}); end
    tick();
    launch(OP_SUB, 16'd1, 16'd6, lat, bc);
    checks++; if (sum !== 32'hFFFFFFFB) begin errors++; $display("FAIL sub_1_6_sum got %h want fffffffb", sum); end
    checks++; if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL sub_1_6_flags got %b want 00", {carry, overflow}); end
    tick();
  endtask

  task automatic test_saturate();
    int lat, bc;
    launch(OP_ADD, 16'h7FFF, 16'h0001, lat, bc);
    checks++; if (sum !== 32'hFFFF8000) begin errors++; $display("FAIL wrap_add_sum got %h want ffff8000", sum); end
    checks++; if ({carry, overflow} !== 2'b01) begin errors++; $display("FAIL wrap_add_flags got %b want 01", {carry, overflow}); end
    tick();
    launch(OP_ADDS, 16'h7FFF, 16'h0001, lat, bc);
    checks++; if (sum !== 32'h00007FFF) begin errors++; $display("FAIL sat_add_sum got %h want 00007fff", sum); end
    checks++; if ({carry, overflow} !== 2'b01) begin errors++; $display("FAIL sat_add_flags got %b want 01", {carry, overflow}); end
    tick();
    launch(OP_SUBS, 16'h8000, 16'h0001, lat, bc);
    checks++; if (sum !== 32'hFFFF8000) begin errors++; $display("FAIL sat_sub_sum got %h want ffff8000", sum); end
    checks++; if ({carry, overflow} !== 2'b11) begin errors++; $display("FAIL sat_sub_flags got %b want 11", {carry, overflow}); end
    tick();
    launch(OP_SUB, 16'h8000, 16'h0001, lat, bc);
    checks++; if (sum !== 32'h00007FFF) begin errors++; $display("FAIL wrap_sub_sum got %h want 00007fff", sum); end
    checks++; if ({carry, overflow} !== 2'b11) begin errors++; $display("FAIL wrap_sub_flags got %b want 11", {carry, overflow}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    op = OP_ADD; a = 16'd6; b = 16'd1; start = 1'b1;
    tick();
    lat = 1;
    while (!done && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_first_latency got %0d want 5", lat); end
    checks++; if (sum !== 32'h00000007) begin errors++; $display("FAIL b2b_first_sum got %h want 00000007", sum); end
    a = 16'd1; b = 16'd2;
    tick();
    gap = 1;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_no_idle got busy,done=%b want 10", {busy, done}); end
    while (!done && gap < 20) begin tick(); gap++; end
    checks++; if (gap !== 5) begin errors++; $display("FAIL b2b_period got %0d want 5", gap); end
    checks++; if (sum !== 32'h00000003) begin errors++; $display("FAIL b2b_second_sum got %h want 00000003", sum); end
    start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_start_in_run();
    int lat;
    op = OP_ADD; a = 16'd2; b = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Pulse start with different operands while RUN is in progress.
    op = OP_SUB; a = 16'd100; b = 16'd50; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL run_start_latency got %0d want 5", lat); end
    checks++; if (sum !== 32'h00000005) begin errors++; $display("FAIL run_start_sum got %h want 00000005", sum); end
    tick(); tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL run_start_not_queued got busy,done=%b want 00", {busy, done}); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    launch(OP_SUB, 16'd6, 16'd1, lat, bc);
    tick();
    op = OP_ADD; a = 16'd9; b = 16'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_ctrl got busy,done=%b want 00", {busy, done}); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL midrst_sum got %h want 00000000", sum); end
    checks++; if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b want 00", {carry, overflow}); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
  endtask

  task automatic test_width8();
    int l1, l8, bc1;
    op8 = OP_ADD; a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    l1 = 0; l8 = 0; bc1 = 0;
    for (int cyc = 1; cyc < 16; cyc++) begin
      if (busy1) bc1++;
      if (done1 && l1 == 0) l1 = cyc;
      if (done8 && l8 == 0) l8 = cyc;
      tick();
    end
    checks++; if (bc1 !== 8) begin errors++; $display("FAIL d1_busy_cycles got %0d want 8", bc1); end
    checks++; if (l1 !== 9) begin errors++; $display("FAIL d1_latency got %0d want 9", l1); end
    checks++; if (sum1 !== 16'h0000) begin errors++; $display("FAIL d1_sum got %h want 0000", sum1); end
    checks++; if ({carry1, ov1} !== 2'b10) begin errors++; $display("FAIL d1_flags got %b want 10", {carry1, ov1}); end
    checks++; if (l8 !== 2) begin errors++; $display("FAIL d8_latency got %0d want 2", l8); end
    checks++; if (sum8 !== 16'h0000) begin errors++; $display("FAIL d8_sum got %h want 0000", sum8); end
    checks++; if ({carry8, ov8} !== 2'b10) begin errors++; $display("FAIL d8_flags got %b want 10", {carry8, ov8}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_saturate();
    test_back_to_back();
    test_start_in_run();
    test_reset_mid();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle two's-complement adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, and adds optional saturating modes. It returns a sign-extended 2·WIDTH result with carry and overflow flags over a start/busy/done handshake. It sits behind the command decoder as the add/sub channel source of the BreadBoard-level ALU, replacing the combinational 16-bit unit.

## Interface
- WIDTH, 16, operand width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only when the block is ready (IDLE or DONE).
- op  in  2  operation: 00 add, 01 sub, 10 saturating add, 11 saturating sub; latched with start.
- inputA  in  WIDTH  operand A, two's complement; latched with start.
- inputB  in  WIDTH  operand B, two's complement; latched with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result is presented.
- sum  out  2·WIDTH  result, sign-extended from bit WIDTH-1; held until the next done.
- carry  out  1  raw carry out of the MSB (for subtract, 1 = no borrow).
- overflow  out  1  signed overflow: carry out of MSB XOR carry into MSB.

## Operation
- States: IDLE, RUN, DONE. Define N = WIDTH/DIGIT.
- Start accepted (IDLE or DONE with start=1):
  - Latch A.
  - Latch B XOR {WIDTH{op[0]}}.
  - Set carry register = op[0] and digit counter = 0, then go to RUN.
- RUN, each cycle:
  - Add digit[cnt] of A and B' plus carry in the digit_adder.
  - Write the DIGIT result bits into the shift/result register and update carry.
  - Record carry-into-MSB when cnt = N-1.
  - cnt++. After the cycle with cnt = N-1, go to DONE.
- Entering DONE:
  - carry = final carry out; overflow = carry XOR carry-into-MSB.
  - If op[1] and overflow, the WIDTH-bit result becomes 0111…1 when A[WIDTH-1]=0, else 1000…0. Otherwise it is the raw WIDTH-bit sum (wraps modulo 2^WIDTH).
  - sum = result sign-extended to 2·WIDTH.
  - The flags are never altered by saturation.
- DONE: done=1 for exactly one cycle. Next state is RUN if start=1, else IDLE.
- start while in RUN is ignored; operands and op changing during RUN have no effect.
- Reset mid-operation aborts the calculation with no done pulse. sum, carry and overflow return to their reset values.

## Timing
- Reset values: state IDLE; busy 0; done 0; sum 0; carry 0; overflow 0; cnt 0.
- start sampled at edge k → busy=1 in cycles k+1..k+N. At edge k+N+1 sum, carry and overflow update and done=1 for that cycle.
- Latency from start to done is N+1 cycles; throughput is one result per N+1 cycles with back-to-back starts.
- sum, carry and overflow change only on the done edge or on reset.
- busy and done are never high together. There is no combinational path from inputs to outputs.

## Structure
- Package serial_addsub_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_ADDS=2'b10, OP_SUBS=2'b11;
  - the state typedef {IDLE, RUN, DONE}.
- Sub-module digit_adder (parameter DIGIT): combinational ripple adder.
  - Inputs: a[DIGIT], b[DIGIT], cin.
  - Outputs: s[DIGIT], cout, cmsb (carry into the top bit).
  - One instance serves all N digits.
- Top level holds the FSM, counter, operand shift registers, saturation logic and output registers.

## Test plan
- WIDTH=16, DIGIT=4, op=00, A=6, B=1 → after 5 cycles done=1, sum=0x00000007, carry=0, overflow=0; busy high 4 cycles.
- op=01, A=6, B=1 → sum=0x00000005, carry=1, overflow=0. Also op=01, A=1, B=6 → sum=0xFFFFFFFB, carry=0, overflow=0.
- op=00, A=0x7FFF, B=1 → sum=0xFFFF8000, overflow=1, carry=0. Same operands with op=10 → sum=0x00007FFF, overflow=1.
- op=11, A=0x8000, B=1 → sum=0xFFFF8000, carry=1, overflow=1. Same operands with op=01 → sum=0x00007FFF.
- start held high through DONE → second operation begins with no IDLE cycle, done every 5 cycles. start pulsed during RUN → ignored. rst asserted at RUN cycle 2 → no done, all outputs 0 next cycle.
- WIDTH=8, DIGIT=1, op=00, A=0xFF, B=0x01 → busy 8 cycles, sum=0x0000, carry=1, overflow=0. WIDTH=8, DIGIT=8 → done 2 cycles after start.
